// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------------------------------------------------------------------
// Two-master arbiter that gives the icache or the dcache ownership of the
// single shared memory bus.
//
// Ownership is requested with a level (*_busreq) and granted one cycle later
// (*_busgrant, registered). A granted master keeps the bus until its
// transaction has started (busidle seen low) and finished (busidle high
// again), or until it has sat idle for START_TIMEOUT cycles without starting.
// Every ownership ends with one RELEASE cycle in which nobody owns the bus.
// Ties in IDLE are broken round-robin against the last master served.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   icache_* / dcache_*         per-master request level, idle status,
//                               request-side handshake, address/data and tag;
//                               busgrant, reqack and respcyc go back to them
//   bus_reqcyc/respack/req/     shared-bus request side, driven from the
//   reqtag                      current owner (all 0 when nobody owns it)
//   bus_reqack/respcyc          shared-bus handshakes, routed to the owner only
//   bus_resp/resptag            response data; wired to the caches outside
//                               this block and not used here
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int START_TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      icache_busreq,
    input  logic                      icache_busidle,
    output logic                      icache_busgrant,
    input  logic                      icache_reqcyc,
    input  logic                      icache_respack,
    input  logic [BUS_DATA_WIDTH-1:0] icache_req,
    input  logic [BUS_TAG_WIDTH-1:0]  icache_reqtag,
    output logic                      icache_reqack,
    output logic                      icache_respcyc,

    input  logic                      dcache_busreq,
    input  logic                      dcache_busidle,
    output logic                      dcache_busgrant,
    input  logic                      dcache_reqcyc,
    input  logic                      dcache_respack,
    input  logic [BUS_DATA_WIDTH-1:0] dcache_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dcache_reqtag,
    output logic                      dcache_reqack,
    output logic                      dcache_respcyc,

    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT_I,
        ST_GRANT_D,
        ST_RELEASE
    } state_e;

    typedef enum logic {
        M_ICACHE,
        M_DCACHE
    } master_e;

    state_e           state_q,   state_d;
    master_e          last_q,    last_d;
    logic             grant_i_q, grant_i_d;
    logic             grant_d_q, grant_d_d;
    logic             started_q, started_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic             owner_idle;
    logic             pick_i;
    logic             pick_d;

    // Response data is broadcast to the caches outside this block.
    logic unused_resp;
    assign unused_resp = ^{bus_resp, bus_resptag};

    // Round-robin: on a tie the master that was not served last wins.
    assign pick_d = dcache_busreq && (!icache_busreq || last_q == M_ICACHE);
    assign pick_i = icache_busreq && (!dcache_busreq || last_q == M_DCACHE);

    assign owner_idle = (state_q == ST_GRANT_I) ? icache_busidle : dcache_busidle;

    // NOTE: every signal assigned in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_i_d = grant_i_q;
        grant_d_d = grant_d_q;
        started_d = started_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_d) begin
                    state_d   = ST_GRANT_D;
                    grant_d_d = 1'b1;
                end else if (pick_i) begin
                    state_d   = ST_GRANT_I;
                    grant_i_d = 1'b1;
                end
            end

            ST_GRANT_I, ST_GRANT_D: begin
                // A busreq from the other master simply waits here; the
                // owner is never preempted.
                if (!started_q) begin
                    if (!owner_idle) begin
                        started_d = 1'b1;
                    end else begin
                        if (cnt_q < CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        // Owner never started: revoke once the counter hits
                        // START_TIMEOUT.
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_RELEASE;
                        end
                    end
                end else if (owner_idle) begin
                    state_d = ST_RELEASE;
                end

                if (state_d == ST_RELEASE) begin
                    grant_i_d = 1'b0;
                    grant_d_d = 1'b0;
                    last_d    = (state_q == ST_GRANT_I) ? M_ICACHE : M_DCACHE;
                end
            end

            ST_RELEASE: begin
                state_d   = ST_IDLE;
                started_d = 1'b0;
                cnt_d     = '0;
            end

            default: begin
                state_d   = ST_IDLE;
                grant_i_d = 1'b0;
                grant_d_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_q    <= M_ICACHE;
            grant_i_q <= 1'b0;
            grant_d_q <= 1'b0;
            started_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_i_q <= grant_i_d;
            grant_d_q <= grant_d_d;
            started_q <= started_d;
            cnt_q     <= cnt_d;
        end
    end

    assign icache_busgrant = grant_i_q;
    assign dcache_busgrant = grant_d_q;

    // Request side follows the owner; reset forces state_q to IDLE at once,
    // which drops these to 0 without waiting for a clock.
    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        unique case (state_q)
            ST_GRANT_I: begin
                bus_reqcyc  = icache_reqcyc;
                bus_respack = icache_respack;
                bus_req     = icache_req;
                bus_reqtag  = icache_reqtag;
            end
            ST_GRANT_D: begin
                bus_reqcyc  = dcache_reqcyc;
                bus_respack = dcache_respack;
                bus_req     = dcache_req;
                bus_reqtag  = dcache_reqtag;
            end
            default: ;
        endcase
    end

    assign icache_reqack  = bus_reqack  && (state_q == ST_GRANT_I);
    assign icache_respcyc = bus_respcyc && (state_q == ST_GRANT_I);
    assign dcache_reqack  = bus_reqack  && (state_q == ST_GRANT_D);
    assign dcache_respcyc = bus_respcyc && (state_q == ST_GRANT_D);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// ---------------------------------------------------------------------------
// Self-checking bench for mem_bus_arbiter. Grant timing is checked against
// fixed cycle timelines; every beat driven by a master while it owns the bus
// is pushed to a scoreboard and popped when bus_reqcyc shows it on the shared
// bus.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int TW = 13;
    localparam int DW = 64;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;

    logic          icache_busreq, icache_busidle, icache_busgrant;
    logic          icache_reqcyc, icache_respack;
    logic [DW-1:0] icache_req;
    logic [TW-1:0] icache_reqtag;
    logic          icache_reqack, icache_respcyc;

    logic          dcache_busreq, dcache_busidle, dcache_busgrant;
    logic          dcache_reqcyc, dcache_respack;
    logic [DW-1:0] dcache_req;
    logic [TW-1:0] dcache_reqtag;
    logic          dcache_reqack, dcache_respcyc;

    logic          bus_reqcyc, bus_respack;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack, bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;

    typedef struct {
        logic [DW-1:0] req;
        logic [TW-1:0] tag;
    } beat_t;

    beat_t sb[$];
    beat_t mon_b;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter #(
        .BUS_TAG_WIDTH (TW),
        .BUS_DATA_WIDTH(DW),
        .START_TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_busreq  (icache_busreq),
        .icache_busidle (icache_busidle),
        .icache_busgrant(icache_busgrant),
        .icache_reqcyc  (icache_reqcyc),
        .icache_respack (icache_respack),
        .icache_req     (icache_req),
        .icache_reqtag  (icache_reqtag),
        .icache_reqack  (icache_reqack),
        .icache_respcyc (icache_respcyc),
        .dcache_busreq  (dcache_busreq),
        .dcache_busidle (dcache_busidle),
        .dcache_busgrant(dcache_busgrant),
        .dcache_reqcyc  (dcache_reqcyc),
        .dcache_respack (dcache_respack),
        .dcache_req     (dcache_req),
        .dcache_reqtag  (dcache_reqtag),
        .dcache_reqack  (dcache_reqack),
        .dcache_respcyc (dcache_respcyc),
        .bus_reqcyc     (bus_reqcyc),
        .bus_respack    (bus_respack),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        icache_busreq  = 1'b0;
        icache_busidle = 1'b1;
        icache_reqcyc  = 1'b0;
        icache_respack = 1'b0;
        icache_req     = '0;
        icache_reqtag  = '0;
        dcache_busreq  = 1'b0;
        dcache_busidle = 1'b1;
        dcache_reqcyc  = 1'b0;
        dcache_respack = 1'b0;
        dcache_req     = '0;
        dcache_reqtag  = '0;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b0;
        bus_resp       = '0;
        bus_resptag    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drive one dcache beat and record what the shared bus must show for it.
    task automatic drive_dbeat(input logic [DW-1:0] req, input logic [TW-1:0] tag);
        beat_t b;
        dcache_reqcyc = 1'b1;
        dcache_req    = req;
        dcache_reqtag = tag;
        b.req = req;
        b.tag = tag;
        sb.push_back(b);
    endtask

    // Bus monitor: grants exclusive, and every visible beat matches the
    // oldest one still expected.
    always @(negedge clk) begin
        if (!reset) begin
            check("grant_excl", 64'(icache_busgrant & dcache_busgrant), 64'd0);
            if (bus_reqcyc) begin
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_b = sb.pop_front();
                    check("beat_req", bus_req, mon_b.req);
                    check("beat_tag", 64'(bus_reqtag), 64'(mon_b.tag));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset state ---------------------------------------------------
        do_reset();
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        dcache_req  = 64'hFFFF;
        #1;
        check("rst_gi",      64'(icache_busgrant), 64'd0);
        check("rst_gd",      64'(dcache_busgrant), 64'd0);
        check("rst_reqcyc",  64'(bus_reqcyc),      64'd0);
        check("rst_req",     bus_req,              64'd0);
        check("rst_ireqack", 64'(icache_reqack),   64'd0);
        check("rst_dreqack", 64'(dcache_reqack),   64'd0);
        check("rst_drespcy", 64'(dcache_respcyc),  64'd0);
        idle_inputs();

        // ---- single dcache request, 1-cycle grant latency -------------------
        dcache_busreq = 1'b1;                 // cycle 0
        tick();                               // cycle 1
        check("t1_gd", 64'(dcache_busgrant), 64'd1);
        check("t1_gi", 64'(icache_busgrant), 64'd0);
        dcache_busreq  = 1'b0;
        dcache_busidle = 1'b0;
        drive_dbeat(64'h1000, 13'h0AB);
        dcache_respack = 1'b1;
        bus_reqack     = 1'b1;
        bus_respcyc    = 1'b1;
        #1;
        check("t1_busreq",   bus_req,              64'h1000);
        check("t1_respack",  64'(bus_respack),     64'd1);
        check("t1_ireqack",  64'(icache_reqack),   64'd0);
        check("t1_dreqack",  64'(dcache_reqack),   64'd1);
        check("t1_irespcyc", 64'(icache_respcyc),  64'd0);
        check("t1_drespcyc", 64'(dcache_respcyc),  64'd1);
        tick();                               // cycle 2: transaction done
        idle_inputs();
        dcache_req = 64'h1000;
        check("t1_gd_hold", 64'(dcache_busgrant), 64'd1);
        tick();                               // cycle 3: RELEASE
        check("t1_rel_gd",  64'(dcache_busgrant), 64'd0);
        check("t1_rel_gi",  64'(icache_busgrant), 64'd0);
        check("t1_rel_req", bus_req,              64'd0);
        tick();                               // cycle 4: IDLE
        check("t1_idle_gd", 64'(dcache_busgrant), 64'd0);

        // ---- tie, 10-beat dcache write-back while icache waits --------------
        do_reset();
        icache_busreq = 1'b1;                 // cycle 0
        dcache_busreq = 1'b1;
        tick();                               // cycle 1
        check("t2_tie_gd", 64'(dcache_busgrant), 64'd1);
        check("t2_tie_gi", 64'(icache_busgrant), 64'd0);
        dcache_busreq = 1'b0;                 // no effect after grant
        tick();                               // cycle 2
        for (int k = 0; k < 10; k++) begin    // cycles 2..11
            dcache_busidle = 1'b0;
            drive_dbeat(64'hD000_0000 + 64'(k * 8), 13'(12'h040 + k));
            if (k == 3) begin
                bus_respcyc = 1'b1;
                #1;
                check("t2_drespcyc", 64'(dcache_respcyc), 64'd1);
                check("t2_irespcyc", 64'(icache_respcyc), 64'd0);
                bus_respcyc = 1'b0;
            end
            check("t2_wb_gd", 64'(dcache_busgrant), 64'd1);
            check("t2_wb_gi", 64'(icache_busgrant), 64'd0);
            tick();
        end
        dcache_reqcyc  = 1'b0;                // cycle 12: busidle back to 1
        dcache_busidle = 1'b1;
        check("t2_c12_gd", 64'(dcache_busgrant), 64'd1);
        tick();                               // cycle 13: RELEASE
        check("t2_c13_gd", 64'(dcache_busgrant), 64'd0);
        check("t2_c13_gi", 64'(icache_busgrant), 64'd0);
        tick();                               // cycle 14: IDLE
        check("t2_c14_gi", 64'(icache_busgrant), 64'd0);
        tick();                               // cycle 15
        check("t2_c15_gi", 64'(icache_busgrant), 64'd1);
        check("t2_c15_gd", 64'(dcache_busgrant), 64'd0);

        // ---- icache never starts: grant revoked after TO cycles -------------
        icache_busreq  = 1'b0;
        icache_req     = 64'hABCD;
        icache_reqtag  = 13'h01F;
        icache_respack = 1'b1;
        #1;
        check("t3_mux_req",  bus_req,              64'hABCD);
        check("t3_mux_tag",  64'(bus_reqtag),      64'h01F);
        check("t3_mux_rack", 64'(bus_respack),     64'd1);
        icache_respack = 1'b0;
        for (int k = 1; k < TO; k++) begin
            tick();
            check("t3_held_gi", 64'(icache_busgrant), 64'd1);
        end
        tick();                               // RELEASE after TO grant cycles
        check("t3_rev_gi",  64'(icache_busgrant), 64'd0);
        check("t3_rev_gd",  64'(dcache_busgrant), 64'd0);
        check("t3_rev_req", bus_req,              64'd0);
        icache_busreq = 1'b1;                 // tie offered during RELEASE
        dcache_busreq = 1'b1;                 // is not sampled until IDLE
        tick();                               // IDLE
        check("t3_idle_gi", 64'(icache_busgrant), 64'd0);
        check("t3_idle_gd", 64'(dcache_busgrant), 64'd0);
        tick();                               // icache served last -> dcache
        check("t3_rr_gd", 64'(dcache_busgrant), 64'd1);
        check("t3_rr_gi", 64'(icache_busgrant), 64'd0);

        // ---- asynchronous reset mid-transaction ------------------------------
        dcache_busidle = 1'b0;
        dcache_reqcyc  = 1'b1;                // reset kills this beat before
        dcache_req     = 64'h5555;            // the monitor samples it
        bus_reqack     = 1'b1;
        #1;
        check("t5_pre_reqcyc", 64'(bus_reqcyc), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_reqcyc", 64'(bus_reqcyc),      64'd0);
        check("t5_rst_gd",     64'(dcache_busgrant), 64'd0);
        check("t5_rst_req",    bus_req,              64'd0);
        check("t5_rst_dack",   64'(dcache_reqack),   64'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset         = 1'b0;
        icache_busreq = 1'b1;
        dcache_busreq = 1'b1;
        tick();
        check("t5_tie_gd", 64'(dcache_busgrant), 64'd1);
        check("t5_tie_gi", 64'(icache_busgrant), 64'd0);
        idle_inputs();
        repeat (3) tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
